// File: rtl/deserialiser_wide_if.sv
// Bus bundle for deserialiser_wide: decoder-side inputs and frame-side outputs.
// The slave modport is the deserialiser's view; master is the driver/observer side.
interface deserialiser_wide_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_CNT_WIDTH = 8
);
  localparam int BITS_W = $clog2(DATA_WIDTH + 1);

  logic                      in_soc;
  logic                      in_eoc;
  logic                      in_error;
  logic                      in_data_valid;
  logic                      in_data;

  logic                      out_soc;
  logic                      out_eoc;
  logic                      out_error;
  logic                      out_data_valid;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [BITS_W-1:0]         out_data_bits;
  logic [WORD_CNT_WIDTH-1:0] out_word_count;

  modport master (
    output in_soc, in_eoc, in_error, in_data_valid, in_data,
    input  out_soc, out_eoc, out_error, out_data_valid, out_data,
           out_data_bits, out_word_count
  );

  modport slave (
    input  in_soc, in_eoc, in_error, in_data_valid, in_data,
    output out_soc, out_eoc, out_error, out_data_valid, out_data,
           out_data_bits, out_word_count
  );
endinterface

// File: rtl/deserialiser_wide.sv
// deserialiser_wide: rx-path bit-to-word deserialiser for the ISO14443-3A receive chain.
// Packs decoded bits into DATA_WIDTH-bit words (LSb- or MSb-first), counts words per
// frame (saturating), flushes a partial last word at end of comms, and holds off all
// data after an error until the next start of comms.
// Optional build macro: DESER_PARITY_CHECK_EN adds a per-word odd-parity bit check.
module deserialiser_wide #(
  parameter int DATA_WIDTH     = 8,
  parameter int MSB_FIRST      = 0,
  parameter int WORD_CNT_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  deserialiser_wide_if.slave bus
);

  localparam int BITS_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BITS_W-1:0] FULL = BITS_W'(DATA_WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] ERR    = 2'd3;
`ifdef DESER_PARITY_CHECK_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]                state;
  logic [DATA_WIDTH-1:0]     shift;
  logic [BITS_W-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_ins;
  logic [BITS_W-1:0]         bit_cnt_inc;

  logic                      eoc_q;
  logic                      error_q;
  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [BITS_W-1:0]         bits_q;
  logic [WORD_CNT_WIDTH-1:0] count_q;

  assign bus.out_soc        = bus.in_soc;
  assign bus.out_eoc        = eoc_q;
  assign bus.out_error      = error_q;
  assign bus.out_data_valid = valid_q;
  assign bus.out_data       = data_q;
  assign bus.out_data_bits  = bits_q;
  assign bus.out_word_count = count_q;

  // Shift register image with the incoming bit placed at its position for this bit count.
  always_comb begin
    shift_ins   = shift;
    bit_cnt_inc = bit_cnt + 1'b1;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (((MSB_FIRST != 0) ? (DATA_WIDTH - 1 - i) : i) == int'(bit_cnt))
        shift_ins[i] = bus.in_data;
    end
  end

  // Frame state machine, bit packing, word emission and one-cycle output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      eoc_q   <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      eoc_q   <= 1'b0;
      error_q <= bus.in_error;
      valid_q <= 1'b0;

      if (bus.in_soc) begin
        shift   <= '0;
        bit_cnt <= '0;
        count_q <= '0;
        state   <= bus.in_error ? ERR : DATA;
      end else if (bus.in_eoc) begin
        eoc_q   <= 1'b1;
        if (state == DATA && bit_cnt != '0 && !bus.in_error) begin
          valid_q <= 1'b1;
          data_q  <= shift;
          bits_q  <= bit_cnt;
          count_q <= (count_q == '1) ? count_q : count_q + 1'b1;
        end
`ifdef DESER_PARITY_CHECK_EN
        if (state == PARITY)
          error_q <= 1'b1;
`endif
        shift   <= '0;
        bit_cnt <= '0;
        state   <= IDLE;
      end else if (bus.in_error) begin
        shift   <= '0;
        bit_cnt <= '0;
        state   <= ERR;
      end else if (bus.in_data_valid) begin
        case (state)
          DATA: begin
            if (bit_cnt_inc == FULL) begin
`ifdef DESER_PARITY_CHECK_EN
              shift   <= shift_ins;
              bit_cnt <= FULL;
              state   <= PARITY;
`else
              valid_q <= 1'b1;
              data_q  <= shift_ins;
              bits_q  <= FULL;
              count_q <= (count_q == '1) ? count_q : count_q + 1'b1;
              shift   <= '0;
              bit_cnt <= '0;
`endif
            end else begin
              shift   <= shift_ins;
              bit_cnt <= bit_cnt_inc;
            end
          end
`ifdef DESER_PARITY_CHECK_EN
          PARITY: begin
            if ((^shift) ^ bus.in_data) begin
              valid_q <= 1'b1;
              data_q  <= shift;
              bits_q  <= FULL;
              count_q <= (count_q == '1) ? count_q : count_q + 1'b1;
              state   <= DATA;
            end else begin
              error_q <= 1'b1;
              state   <= ERR;
            end
            shift   <= '0;
            bit_cnt <= '0;
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

endmodule
